// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, receiver states and
// the clocks-per-bit helper used by the transmit and receive paths.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE = 115_200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Whole clock cycles per bit; the fractional part is dropped.
  function automatic int unsigned clks_per_bit(
    input int unsigned clk_freq,
    input int unsigned baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Both stages reset to RST_VAL so an idle-high line stays quiet after reset.
module uart_sync2 #(
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages to settle metastability before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver presenting bytes on a valid/ready stream.
// One byte is held; a completed byte arriving while it is unread is dropped.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_error_o,
  output logic                 overrun_error_o,
  output logic                 busy_o
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(DATA_BITS - 1);

  rx_state_t state, state_n;

  logic                 rxd_s;
  logic                 rxd_q;
  logic                 fall;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 done, done_n;
  logic                 ferr_n;

  uart_sync2 #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (rxd_i),
    .q   (rxd_s)
  );

  assign fall   = rxd_q & ~rxd_s;
  assign busy_o = (state != IDLE);

  // Previous synchronized level for start-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) rxd_q <= 1'b1;
    else       rxd_q <= rxd_s;
  end

  // Next-state logic: half-bit start check, then mid-bit sampling.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n        = '0;
          shift_n[idx] = rxd_s;
          if (idx == IDX_END) state_n = STOP;
          else                idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          state_n = IDLE;
          done_n  = rxd_s;
          ferr_n  = ~rxd_s;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Receiver state, counters, shift register and stop-sample flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      done          <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shift         <= shift_n;
      done          <= done_n;
      frame_error_o <= ferr_n;
    end
  end

  // Output holding register: load, hold until accepted, or flag overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o          <= '0;
      valid_o         <= 1'b0;
      overrun_error_o <= 1'b0;
    end else begin
      overrun_error_o <= 1'b0;
      if (done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift;
          valid_o <= 1'b1;
        end else begin
          overrun_error_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
